// File: rtl/otter_lsu_pkg.sv
// otter_lsu_pkg
// Shared types and constants for the OTTER load/store unit.
//   mem_size_t  : access size encoding driven onto the memory's MEM_SIZE port
//   lsu_state_t : LSU sequencing FSM states
//   OTTER_MMIO_BASE : first byte address of memory-mapped I/O space
//   lsu_is_mmio() : unsigned "address lies in MMIO space" test
package otter_lsu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_WR_ISSUE,
    ST_RESP
  } lsu_state_t;

  localparam logic [31:0] OTTER_MMIO_BASE = 32'h0001_0000;

  function automatic logic lsu_is_mmio(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base);
  endfunction

endpackage

// File: rtl/otter_lsu_align_chk.sv
// otter_lsu_align_chk
// Purely combinational alignment / legality check for an LSU request.
//   i_size    : requested access size (0 byte, 1 half, 2 word, 3 illegal)
//   i_addr_lo : byte offset within the word, addr[1:0]
//   o_err     : 1 when the request must be rejected without memory traffic
// Build option: define LSU_STRICT_ALIGN_EN to require natural alignment for
// half accesses (offsets 1 and 3 rejected). When undefined, only offset 3 is
// rejected, because the memory can serve a half at offset 1 within one word.
module otter_lsu_align_chk
  import otter_lsu_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic       o_err
);

  always_comb begin
    o_err = 1'b0;
    case (i_size)
      MEM_BYTE: o_err = 1'b0;
`ifdef LSU_STRICT_ALIGN_EN
      MEM_HALF: o_err = i_addr_lo[0];
`else
      // A half at offset 3 would straddle two memory words.
      MEM_HALF: o_err = (i_addr_lo == 2'd3);
`endif
      MEM_WORD: o_err = (i_addr_lo != 2'd0);
      default:  o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/otter_lsu.sv
// otter_lsu
// Load/store unit for the OTTER RV32I core: initiator on the data port
// (port 2) of the unified memory. Takes one request at a time, sequences
// the memory's registered-read / registered-write port, and returns a
// one-cycle response with sized load data or an alignment error.
// Ports:
//   LSU_CLK, LSU_RST_N       : clock, asynchronous active-low reset
//   REQ_VALID / REQ_READY    : request handshake (READY only in IDLE)
//   REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_SIGN : request fields
//   RSP_VALID, RSP_RDATA, RSP_ERR, RSP_IO : registered response
//   MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN : memory side
//   MEM_DOUT2                : sized read data, valid the cycle after RDEN2
// Parameter MMIO_BASE: accesses at or above it report RSP_IO.
// Build option: LSU_STRICT_ALIGN_EN (see otter_lsu_align_chk).
// Latency from accept edge to RSP_VALID: load 3, store 2, error 1 cycle(s).
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = OTTER_MMIO_BASE
) (
  input  logic        LSU_CLK,
  input  logic        LSU_RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        RSP_IO,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  lsu_state_t  r_state, w_state_nxt;

  logic        r_mem_rden, w_mem_rden_nxt;
  logic        r_mem_we,   w_mem_we_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_mem_din,  w_mem_din_nxt;
  logic [1:0]  r_mem_size, w_mem_size_nxt;
  logic        r_mem_sign, w_mem_sign_nxt;

  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err,   w_rsp_err_nxt;
  logic        r_rsp_io,    w_rsp_io_nxt;

  logic        w_align_err;
  logic        w_accept;

  otter_lsu_align_chk u_align_chk (
    .i_size    (REQ_SIZE),
    .i_addr_lo (REQ_ADDR[1:0]),
    .o_err     (w_align_err)
  );

  assign REQ_READY = (r_state == ST_IDLE);
  assign w_accept  = REQ_VALID && REQ_READY;

  // Next-state and next-output logic; every output except REQ_READY is
  // registered from these values.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_rden_nxt  = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_din_nxt   = r_mem_din;
    w_mem_size_nxt  = r_mem_size;
    w_mem_sign_nxt  = r_mem_sign;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_io_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_mem_addr_nxt = REQ_ADDR;
          w_mem_din_nxt  = REQ_WDATA;
          w_mem_size_nxt = REQ_SIZE;
          w_mem_sign_nxt = REQ_SIGN;
          if (w_align_err) begin
            // Error responds immediately; REQ_ADDR is the value being
            // registered this edge, so the MMIO test matches the held address.
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_io_nxt    = lsu_is_mmio(REQ_ADDR, MMIO_BASE);
            w_rsp_rdata_nxt = 32'd0;
          end else if (REQ_WE) begin
            w_state_nxt  = ST_WR_ISSUE;
            w_mem_we_nxt = 1'b1;
          end else begin
            w_state_nxt    = ST_RD_ISSUE;
            w_mem_rden_nxt = 1'b1;
          end
        end
      end
      ST_RD_ISSUE: begin
        w_state_nxt = ST_RD_CAPTURE;
      end
      ST_RD_CAPTURE: begin
        // Memory output is valid this cycle; address/size/sign still held.
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = MEM_DOUT2;
        w_rsp_io_nxt    = lsu_is_mmio(r_mem_addr, MMIO_BASE);
      end
      ST_WR_ISSUE: begin
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = 32'd0;
        w_rsp_io_nxt    = lsu_is_mmio(r_mem_addr, MMIO_BASE);
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge LSU_CLK or negedge LSU_RST_N) begin
    if (!LSU_RST_N) begin
      r_state     <= ST_IDLE;
      r_mem_rden  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_din   <= 32'd0;
      r_mem_size  <= MEM_WORD;
      r_mem_sign  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_rsp_io    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_rden  <= w_mem_rden_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_din   <= w_mem_din_nxt;
      r_mem_size  <= w_mem_size_nxt;
      r_mem_sign  <= w_mem_sign_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_io    <= w_rsp_io_nxt;
    end
  end

  assign MEM_RDEN2 = r_mem_rden;
  assign MEM_WE2   = r_mem_we;
  assign MEM_ADDR2 = r_mem_addr;
  assign MEM_DIN2  = r_mem_din;
  assign MEM_SIZE  = r_mem_size;
  assign MEM_SIGN  = r_mem_sign;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;
  assign RSP_IO    = r_rsp_io;

endmodule

// File: tb/tb_otter_lsu.sv
// tb_otter_lsu
// Scoreboard bench for otter_lsu: requests push their expected response,
// a negedge monitor pops and compares when RSP_VALID appears, and counts
// memory enable pulses per transaction. Includes a behavioural model of the
// OTTER memory data port (registered sized read, registered write, MMIO word).
module tb_otter_lsu;
  import otter_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        REQ_VALID, REQ_READY, REQ_WE, REQ_SIGN;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        RSP_VALID, RSP_ERR, RSP_IO;
  logic [31:0] RSP_RDATA;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
  logic [1:0]  MEM_SIZE;

  always #5 clk = ~clk;

  otter_lsu dut (
    .LSU_CLK   (clk),
    .LSU_RST_N (rst_n),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_SIZE  (REQ_SIZE),
    .REQ_SIGN  (REQ_SIGN),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .RSP_IO    (RSP_IO),
    .MEM_RDEN2 (MEM_RDEN2),
    .MEM_WE2   (MEM_WE2),
    .MEM_ADDR2 (MEM_ADDR2),
    .MEM_DIN2  (MEM_DIN2),
    .MEM_SIZE  (MEM_SIZE),
    .MEM_SIGN  (MEM_SIGN),
    .MEM_DOUT2 (MEM_DOUT2)
  );

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:4095];
  logic [31:0] io_word;
  logic [31:0] mem_q;
  assign MEM_DOUT2 = mem_q;

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] w;
    logic [11:0] i0, i1, i2, i3;
    i0 = a[11:0];
    i1 = i0 + 12'd1;
    i2 = i0 + 12'd2;
    i3 = i0 + 12'd3;
    if (a >= OTTER_MMIO_BASE) w = io_word;
    else w = {mem[i3], mem[i2], mem[i1], mem[i0]};
    case (sz)
      2'd0:    return uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    return uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (MEM_WE2 && MEM_ADDR2 < OTTER_MMIO_BASE) begin
      mem[MEM_ADDR2[11:0]] <= MEM_DIN2[7:0];
      if (MEM_SIZE != 2'd0) mem[MEM_ADDR2[11:0] + 12'd1] <= MEM_DIN2[15:8];
      if (MEM_SIZE == 2'd2) begin
        mem[MEM_ADDR2[11:0] + 12'd2] <= MEM_DIN2[23:16];
        mem[MEM_ADDR2[11:0] + 12'd3] <= MEM_DIN2[31:24];
      end
    end
    if (MEM_RDEN2) mem_q <= mem_rd(MEM_ADDR2, MEM_SIZE, MEM_SIGN);
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  size;
    logic        uns, err, io;
    int          lat, nrd, nwr, acc;
  } exp_t;

  exp_t sb[$];

  int          cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0;
  int          last_rsp_cyc = 0, prev_rsp_cyc = 0, last_acc = 0;
  logic        post_rsp = 1'b0;
  logic [31:0] last_rdata = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (post_rsp) begin
        check_eq("err_clear", 32'(RSP_ERR), 32'd0);
        check_eq("io_clear", 32'(RSP_IO), 32'd0);
        check_eq("rdata_hold", RSP_RDATA, last_rdata);
        post_rsp = 1'b0;
      end
      if (MEM_RDEN2 || MEM_WE2) begin
        if (sb.size() == 0) begin
          check_eq("spurious_mem", 32'({MEM_RDEN2, MEM_WE2}), 32'd0);
        end else begin
          if (MEM_RDEN2) rd_cnt++;
          if (MEM_WE2) begin
            wr_cnt++;
            check_eq("mem_din", MEM_DIN2, sb[0].wdata);
          end
          check_eq("mem_addr", MEM_ADDR2, sb[0].addr);
          check_eq("mem_size", 32'(MEM_SIZE), 32'(sb[0].size));
          check_eq("mem_sign", 32'(MEM_SIGN), 32'(sb[0].uns));
        end
      end
      if (RSP_VALID) begin
        rsp_cnt++;
        prev_rsp_cyc = last_rsp_cyc;
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          check_eq("unexpected_rsp", 32'(RSP_VALID), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_rdata", RSP_RDATA, e.rdata);
          check_eq("rsp_err", 32'(RSP_ERR), 32'(e.err));
          check_eq("rsp_io", 32'(RSP_IO), 32'(e.io));
          check_eq("rsp_lat", 32'(cyc - e.acc + 1), 32'(e.lat));
          check_eq("rden_pulses", 32'(rd_cnt), 32'(e.nrd));
          check_eq("we_pulses", 32'(wr_cnt), 32'(e.nwr));
          last_rdata = e.rdata;
          post_rsp = 1'b1;
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      check_eq("rsp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Called at a negedge. Latency and enable pulses follow from the
  // expected error flag and the request direction.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic [31:0] e_rdata,
                        input logic e_err, input logic e_io, input logic keep);
    exp_t e;
    int w = 0;
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    REQ_SIZE  = size;
    REQ_SIGN  = uns;
    while (!REQ_READY && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!REQ_READY) check_eq("req_ready_timeout", 32'(REQ_READY), 32'd1);
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = e_rdata;
    e.size  = size;
    e.uns   = uns;
    e.err   = e_err;
    e.io    = e_io;
    e.nrd   = (!e_err && !we) ? 1 : 0;
    e.nwr   = (!e_err && we) ? 1 : 0;
    e.lat   = e_err ? 1 : (we ? 2 : 3);
    e.acc   = cyc + 1;
    @(posedge clk);
    sb.push_back(e);
    last_acc = e.acc;
    #1;
    if (!keep) begin
      REQ_VALID = 1'b0;
      drain();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ctl"},
             32'({REQ_READY, RSP_VALID, RSP_ERR, RSP_IO, MEM_RDEN2, MEM_WE2, MEM_SIZE, MEM_SIGN}),
             32'h104);
    check_eq({tag, "_addr"}, MEM_ADDR2, 32'd0);
    check_eq({tag, "_din"}, MEM_DIN2, 32'd0);
    check_eq({tag, "_rdata"}, RSP_RDATA, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, rsp_before;
    rst_n     = 1'b1;
    io_word   = 32'h0000_00A5;
    REQ_VALID = 1'b0;
    REQ_WE    = 1'b0;
    REQ_ADDR  = 32'd0;
    REQ_WDATA = 32'd0;
    REQ_SIZE  = 2'd2;
    REQ_SIGN  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Preload memory through the LSU itself.
    do_req(1'b1, 32'h100, 32'h80FF_1234, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 32'h000, 32'h00AB_CD00, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 32'h080, 32'h0000_0000, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Signed byte load of the top byte.
    do_req(1'b0, 32'h103, 32'd0, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0);
    // Word store then unsigned half load of its upper half.
    do_req(1'b1, 32'h040, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 32'h042, 32'd0, 2'd1, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0);
    // Misaligned word load.
    do_req(1'b0, 32'h042, 32'd0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    // Half at offset 1.
`ifdef LSU_STRICT_ALIGN_EN
    do_req(1'b0, 32'h001, 32'd0, 2'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
`else
    do_req(1'b0, 32'h001, 32'd0, 2'd1, 1'b0, 32'hFFFF_ABCD, 1'b0, 1'b0, 1'b0);
`endif
    // Half at offset 3, illegal size, misaligned store.
    do_req(1'b0, 32'h043, 32'd0, 2'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    do_req(1'b0, 32'h040, 32'd0, 2'd3, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    do_req(1'b1, 32'h041, 32'h1111_2222, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    // Signed half and unsigned byte loads.
    do_req(1'b0, 32'h040, 32'd0, 2'd1, 1'b0, 32'hFFFF_BEEF, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 32'h103, 32'd0, 2'd0, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    // Misaligned access in MMIO space still reports IO.
    do_req(1'b0, 32'h0001_0002, 32'd0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // MMIO load with REQ_VALID held high into a second request.
    do_req(1'b0, 32'h1100_0000, 32'd0, 2'd2, 1'b0, 32'h0000_00A5, 1'b0, 1'b1, 1'b1);
    acc1 = last_acc;
    @(negedge clk);
    do_req(1'b0, 32'h040, 32'd0, 2'd0, 1'b1, 32'h0000_00EF, 1'b0, 1'b0, 1'b0);
    check_eq("hold_spacing", 32'(last_acc - acc1), 32'd4);
    check_eq("hold_after_rsp", 32'(last_acc - prev_rsp_cyc), 32'd2);

    // Reset while the store is in WR_ISSUE.
    rsp_before = rsp_cnt;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_ADDR  = 32'h080;
    REQ_WDATA = 32'h1234_5678;
    REQ_SIZE  = 2'd2;
    REQ_SIGN  = 1'b0;
    check_eq("abort_ready", 32'(REQ_READY), 32'd1);
    @(posedge clk);
    #1 REQ_VALID = 1'b0;
    #1 check_eq("abort_we_on", 32'(MEM_WE2), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_we_drop", 32'(MEM_WE2), 32'd0);
    check_eq("abort_ready_rst", 32'(REQ_READY), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("abort");
    repeat (6) @(negedge clk);
    check_eq("abort_no_rsp", 32'(rsp_cnt - rsp_before), 32'd0);
    // The aborted store must not have reached memory.
    do_req(1'b0, 32'h080, 32'd0, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
